// File: rtl/pixel_stream_pkg.sv
// pixel_stream_pkg
//   Shared types and helpers for the pixel stream generator.
//   mode_e     : source address mapping applied to the raster output order
//   state_e    : frame sequencing states of pixel_stream_gen
//   SKID_DEPTH : entries in the output skid buffer
//   addr_width : index width for a table of a given depth (minimum 1 bit)
package pixel_stream_pkg;

    typedef enum logic [1:0] {
        IDENT  = 2'd0,
        HFLIP  = 2'd1,
        VFLIP  = 2'd2,
        ROT180 = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_e;

    localparam int SKID_DEPTH = 2;

    function automatic int addr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/pixel_rom.sv
// pixel_rom
//   Synchronous-read pixel ROM with LANES independent read ports and one
//   cycle of read latency. Word a holds a mod 2^PIX_W.
//   Ports:
//     clk   : clock
//     rst_n : asynchronous active-low reset, clears the read registers
//     en    : read enable, all ports capture together
//     addr  : LANES packed addresses, port k in [k*AW +: AW]
//     data  : LANES packed words, port k in [k*PIX_W +: PIX_W]
module pixel_rom
    import pixel_stream_pkg::*;
#(
    parameter int    DEPTH     = 784,
    parameter int    PIX_W     = 8,
    parameter int    LANES     = 1,
    parameter string INIT_FILE = "",
    parameter int    AW        = addr_width(DEPTH)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   en,
    input  logic [LANES*AW-1:0]    addr,
    output logic [LANES*PIX_W-1:0] data
);

    // Image files are bound by the technology ROM wrapper; this model only
    // carries the built-in address pattern, so a file request is refused
    // rather than silently producing the wrong image.
    if (INIT_FILE != "") begin : g_init_file_check
        $error("pixel_rom: INIT_FILE '%s' not supported by the behavioural ROM", INIT_FILE);
    end

    if (DEPTH < 1) begin : g_depth_check
        $error("pixel_rom: DEPTH must be positive");
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data <= '0;
        end else if (en) begin
            for (int k = 0; k < LANES; k++) begin
                data[k*PIX_W +: PIX_W] <= PIX_W'(addr[k*AW +: AW]);
            end
        end
    end

endmodule

// File: rtl/pixel_stream_gen.sv
// pixel_stream_gen
//   Streams one IMG_W x IMG_H frame from pixel_rom in raster order, LANES
//   pixels per beat, with the source address remapped by the latched mode.
//   Ports:
//     clk_i   : clock, rising edge
//     rst_ni  : asynchronous active-low reset
//     start_i : frame request, honoured only in IDLE outside the done cycle
//     mode_i  : address mode (mode_e), latched on an accepted start
//     ready_i : downstream ready
//     pixel_o : beat data, lane k in [k*PIX_W +: PIX_W], lane 0 = lowest column
//     valid_o : pixel_o / last_o valid
//     last_o  : final beat of the frame
//     busy_o  : accepted start through the done_o cycle inclusive
//     done_o  : one-cycle pulse after the last beat's handshake
//
//   state | meaning
//   IDLE  | waiting for start_i; done_o cycle also spent here
//   RUN   | issuing ROM reads as skid-buffer space allows
//   DRAIN | all reads issued, waiting for the last beat's handshake
module pixel_stream_gen
    import pixel_stream_pkg::*;
#(
    parameter int IMG_W = 28,
    parameter int IMG_H = 28,
    parameter int PIX_W = 8,
    parameter int LANES = 1
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   start_i,
    input  logic [1:0]             mode_i,
    input  logic                   ready_i,
    output logic [LANES*PIX_W-1:0] pixel_o,
    output logic                   valid_o,
    output logic                   last_o,
    output logic                   busy_o,
    output logic                   done_o
);

    localparam int NPIX = IMG_W * IMG_H;
    localparam int AW   = addr_width(NPIX);
    localparam int CW   = addr_width(IMG_W);
    localparam int RW   = addr_width(IMG_H);
    localparam int BW   = LANES * PIX_W;
    localparam int CNTW = $clog2(SKID_DEPTH + 1);
    localparam int OW   = CNTW + 1;

    localparam logic [CW-1:0] COL_LAST   = CW'(IMG_W - LANES);
    localparam logic [CW-1:0] COL_STEP   = CW'(LANES);
    localparam logic [RW-1:0] ROW_LAST   = RW'(IMG_H - 1);
    localparam logic [AW-1:0] ROW_STEP   = AW'(IMG_W);
    localparam logic [AW-1:0] VBASE_INIT = AW'((IMG_H - 1) * IMG_W);

    if (IMG_W % LANES != 0) begin : g_lane_check
        $error("pixel_stream_gen: IMG_W (%0d) is not a multiple of LANES (%0d)", IMG_W, LANES);
    end

    if (IMG_W < 2 || IMG_H < 2) begin : g_size_check
        $error("pixel_stream_gen: image must be at least 2x2");
    end

    state_e                  state_q, state_d;
    mode_e                   mode_q;
    logic                    done_q;
    logic                    accept, finish;

    logic [RW-1:0]           row_q;
    logic [CW-1:0]           col_q;
    logic [AW-1:0]           row_base_q;
    logic [AW-1:0]           vrow_base_q;

    logic                    issue, issue_last, space_ok;
    logic [LANES*AW-1:0]     rom_addr;
    logic [BW-1:0]           rom_data;
    logic                    rom_vld_q, rom_last_q;

    logic [SKID_DEPTH-1:0][BW-1:0] skid_data_q;
    logic [SKID_DEPTH-1:0]         skid_last_q;
    logic                          wr_ptr_q, rd_ptr_q;
    logic [CNTW-1:0]               cnt_q;
    logic                          push, pop;

    // ------------------------------------------------------------------
    // Frame sequencing
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= finish;
        end
    end

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        finish  = 1'b0;
        case (state_q)
            IDLE: begin
                // done_q blocks the start sampled in the done cycle itself
                if (start_i && !done_q) begin
                    accept  = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (issue && issue_last) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (pop && last_o) begin
                    finish  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Address generator: running row bases replace r*IMG_W
    // ------------------------------------------------------------------
    assign issue_last = (row_q == ROW_LAST) && (col_q == COL_LAST);

    // Projected occupancy at the edge that delivers this read's data must
    // leave room for it; counting the in-flight read keeps two entries enough.
    assign space_ok = ({1'b0, cnt_q} + OW'(rom_vld_q) - OW'(pop)) < OW'(SKID_DEPTH);
    assign issue    = (state_q == RUN) && space_ok;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mode_q      <= IDENT;
            row_q       <= '0;
            col_q       <= '0;
            row_base_q  <= '0;
            vrow_base_q <= '0;
        end else if (accept) begin
            mode_q      <= mode_e'(mode_i);
            row_q       <= '0;
            col_q       <= '0;
            row_base_q  <= '0;
            vrow_base_q <= VBASE_INIT;
        end else if (issue) begin
            if (col_q == COL_LAST) begin
                col_q       <= '0;
                row_q       <= row_q + RW'(1);
                row_base_q  <= row_base_q + ROW_STEP;
                vrow_base_q <= vrow_base_q - ROW_STEP;
            end else begin
                col_q <= col_q + COL_STEP;
            end
        end
    end

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        logic [AW-1:0] lin;
        logic [AW-1:0] src;

        assign lin = row_base_q + AW'(col_q) + AW'(k);

        always_comb begin
            src = lin;
            case (mode_q)
                IDENT:   src = lin;
                HFLIP:   src = row_base_q + AW'(IMG_W - 1 - k) - AW'(col_q);
                VFLIP:   src = vrow_base_q + AW'(col_q) + AW'(k);
                ROT180:  src = AW'(NPIX - 1) - lin;
                default: src = lin;
            endcase
        end

        assign rom_addr[k*AW +: AW] = src;
    end

    pixel_rom #(
        .DEPTH     (NPIX),
        .PIX_W     (PIX_W),
        .LANES     (LANES),
        .INIT_FILE (""),
        .AW        (AW)
    ) u_rom (
        .clk   (clk_i),
        .rst_n (rst_ni),
        .en    (issue),
        .addr  (rom_addr),
        .data  (rom_data)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rom_vld_q  <= 1'b0;
            rom_last_q <= 1'b0;
        end else begin
            rom_vld_q  <= issue;
            rom_last_q <= issue && issue_last;
        end
    end

    // ------------------------------------------------------------------
    // Skid buffer: absorbs the read already in flight when ready_i drops
    // ------------------------------------------------------------------
    assign push = rom_vld_q;
    assign pop  = valid_o && ready_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            skid_data_q <= '0;
            skid_last_q <= '0;
            wr_ptr_q    <= 1'b0;
            rd_ptr_q    <= 1'b0;
            cnt_q       <= '0;
        end else begin
            if (push) begin
                skid_data_q[wr_ptr_q] <= rom_data;
                skid_last_q[wr_ptr_q] <= rom_last_q;
                wr_ptr_q              <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            case ({push, pop})
                2'b10:   cnt_q <= cnt_q + CNTW'(1);
                2'b01:   cnt_q <= cnt_q - CNTW'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    assign valid_o = (cnt_q != '0);
    assign pixel_o = skid_data_q[rd_ptr_q];
    assign last_o  = valid_o && skid_last_q[rd_ptr_q];
    assign busy_o  = (state_q != IDLE) || done_q;
    assign done_o  = done_q;

endmodule

// File: tb/tb_pixel_stream_gen.sv
module tb_pixel_stream_gen;

    localparam int W    = 28;
    localparam int H    = 28;
    localparam int NPIX = W * H;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start, start4;
    logic [1:0]  mode, mode4;
    logic        ready, ready4;
    logic [7:0]  pixel;
    logic        valid, last, busy, done;
    logic [31:0] pixel4;
    logic        valid4, last4, busy4, done4;

    int n_tests = 0;
    int n_fail  = 0;

    // results of the most recent run_frame
    int   r_lat, r_beats, r_err, r_nlast, r_last_pos, r_stall_err, r_cyc;
    int   r_first, r_lastv, r_v28;
    logic r_done1, r_busy1, r_done2, r_busy2;

    always #5 clk = ~clk;

    pixel_stream_gen #(.IMG_W(W), .IMG_H(H), .PIX_W(8), .LANES(1)) dut (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .start_i (start),
        .mode_i  (mode),
        .ready_i (ready),
        .pixel_o (pixel),
        .valid_o (valid),
        .last_o  (last),
        .busy_o  (busy),
        .done_o  (done)
    );

    pixel_stream_gen #(.IMG_W(W), .IMG_H(H), .PIX_W(8), .LANES(4)) dut4 (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .start_i (start4),
        .mode_i  (mode4),
        .ready_i (ready4),
        .pixel_o (pixel4),
        .valid_o (valid4),
        .last_o  (last4),
        .busy_o  (busy4),
        .done_o  (done4)
    );

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
        end
    endtask

    function automatic logic [7:0] exp_pix(input int m, input int r, input int c);
        int a;
        case (m)
            0:       a = r * W + c;
            1:       a = r * W + (W - 1 - c);
            2:       a = (H - 1 - r) * W + c;
            default: a = NPIX - 1 - (r * W + c);
        endcase
        return 8'(a % 256);
    endfunction

    // One LANES=1 frame; mode_i is inverted right after acceptance so any
    // mid-frame mode leakage shows up as value errors.
    task automatic run_frame(input logic [1:0] m, input bit rnd, input bit hold);
        int   guard;
        bit   stalled;
        logic [7:0] held_pix;
        logic held_last;
        logic [7:0] e;
        r_lat = 0; r_beats = 0; r_err = 0; r_nlast = 0; r_last_pos = -1;
        r_stall_err = 0; r_cyc = 0; r_first = -1; r_lastv = -1; r_v28 = -1;
        held_pix = '0; held_last = 1'b0; stalled = 1'b0;
        @(negedge clk);
        mode  = m;
        start = 1'b1;
        ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        @(posedge clk);
        @(negedge clk);
        if (!hold) start = 1'b0;
        mode = ~m;
        guard = 0;
        while (valid !== 1'b1 && guard < 10) begin
            @(posedge clk);
            r_lat++;
            @(negedge clk);
            guard++;
        end
        guard = 0;
        while (r_beats < NPIX && guard < 20000) begin
            if (stalled && (valid !== 1'b1 || pixel !== held_pix || last !== held_last))
                r_stall_err++;
            ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            stalled = 1'b0;
            if (valid === 1'b1) begin
                if (ready) begin
                    e = exp_pix(int'(m), r_beats / W, r_beats % W);
                    if (pixel !== e) r_err++;
                    if (last === 1'b1) begin
                        r_nlast++;
                        r_last_pos = r_beats;
                    end
                    if (r_beats == 0)        r_first = int'(pixel);
                    if (r_beats == 28)       r_v28   = int'(pixel);
                    if (r_beats == NPIX - 1) r_lastv = int'(pixel);
                    r_beats++;
                end else begin
                    stalled   = 1'b1;
                    held_pix  = pixel;
                    held_last = last;
                end
            end
            r_cyc++;
            @(posedge clk);
            @(negedge clk);
            guard++;
        end
        r_done1 = done;
        r_busy1 = busy;
        @(posedge clk);
        @(negedge clk);
        r_done2 = done;
        r_busy2 = busy;
    endtask

    initial begin
        int   beats, err, guard, last_pos, nd;
        bit   restarted;
        logic [31:0] e4, first4;

        rst_n = 1'b0; start = 1'b0; start4 = 1'b0;
        mode = 2'd0; mode4 = 2'd0; ready = 1'b0; ready4 = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_valid", 32'(valid), 32'd0);
        check("rst_pixel", 32'(pixel), 32'd0);
        check("rst_last",  32'(last),  32'd0);
        check("rst_busy",  32'(busy),  32'd0);
        check("rst_done",  32'(done),  32'd0);
        rst_n = 1'b1;

        ready = 1'b1;
        repeat (3) @(negedge clk);
        check("idle_ready_no_valid", 32'({valid, busy}), 32'd0);

        // IDENT, ready held high
        run_frame(2'd0, 1'b0, 1'b0);
        check("ident_latency",   32'(r_lat),      32'd2);
        check("ident_beats",     32'(r_beats),    32'(NPIX));
        check("ident_errors",    32'(r_err),      32'd0);
        check("ident_cycles",    32'(r_cyc),      32'(NPIX));
        check("ident_first",     32'(r_first),    32'd0);
        check("ident_last_val",  32'(r_lastv),    32'd15);
        check("ident_nlast",     32'(r_nlast),    32'd1);
        check("ident_last_pos",  32'(r_last_pos), 32'(NPIX - 1));
        check("ident_done1",     32'(r_done1),    32'd1);
        check("ident_busy1",     32'(r_busy1),    32'd1);
        check("ident_done2",     32'(r_done2),    32'd0);
        check("ident_busy2",     32'(r_busy2),    32'd0);

        // HFLIP
        run_frame(2'd1, 1'b0, 1'b0);
        check("hflip_first",  32'(r_first), 32'd27);
        check("hflip_beat28", 32'(r_v28),   32'd55);
        check("hflip_errors", 32'(r_err),   32'd0);

        // ROT180
        run_frame(2'd3, 1'b0, 1'b0);
        check("rot_first",    32'(r_first),    32'd15);
        check("rot_last_val", 32'(r_lastv),    32'd0);
        check("rot_errors",   32'(r_err),      32'd0);
        check("rot_last_pos", 32'(r_last_pos), 32'(NPIX - 1));

        // IDENT with random backpressure
        run_frame(2'd0, 1'b1, 1'b0);
        check("bp_beats",      32'(r_beats),     32'(NPIX));
        check("bp_errors",     32'(r_err),       32'd0);
        check("bp_stall_hold", 32'(r_stall_err), 32'd0);
        check("bp_nlast",      32'(r_nlast),     32'd1);
        check("bp_done1",      32'(r_done1),     32'd1);
        ready = 1'b1;

        // LANES=4 VFLIP
        @(negedge clk);
        mode4 = 2'd2; start4 = 1'b1; ready4 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start4 = 1'b0;
        beats = 0; err = 0; guard = 0; last_pos = -1; first4 = '0;
        while (beats < NPIX / 4 && guard < 2000) begin
            if (valid4 === 1'b1) begin
                for (int k = 0; k < 4; k++)
                    e4[k*8 +: 8] = exp_pix(2, beats / 7, (beats % 7) * 4 + k);
                if (pixel4 !== e4) err++;
                if (beats == 0) first4 = pixel4;
                if (last4 === 1'b1) last_pos = beats;
                beats++;
            end
            @(posedge clk);
            @(negedge clk);
            guard++;
        end
        check("l4_beats",    32'(beats),    32'(NPIX / 4));
        check("l4_first",    first4,        32'hF7F6F5F4);
        check("l4_errors",   32'(err),      32'd0);
        check("l4_last_pos", 32'(last_pos), 32'(NPIX / 4 - 1));
        check("l4_done",     32'(done4),    32'd1);

        // restart ignored at beat 100, reset at beat 300
        @(negedge clk);
        mode = 2'd0; start = 1'b1; ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        beats = 0; err = 0; guard = 0; restarted = 1'b0;
        while (beats < 300 && guard < 1000) begin
            if (beats == 100 && !restarted) begin
                start = 1'b1;
                mode = 2'd3;
                restarted = 1'b1;
            end else begin
                start = 1'b0;
            end
            if (valid === 1'b1) begin
                if (pixel !== 8'(beats % 256)) err++;
                beats++;
            end
            @(posedge clk);
            @(negedge clk);
            guard++;
        end
        start = 1'b0;
        check("restart_beats",  32'(beats), 32'd300);
        check("restart_errors", 32'(err),   32'd0);
        rst_n = 1'b0;
        #1;
        check("midreset_outputs", 32'({pixel, valid, last, busy, done}), 32'd0);
        nd = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) begin
            @(negedge clk);
            nd = nd | int'({done, busy, valid});
        end
        check("midreset_no_done", 32'(nd), 32'd0);

        run_frame(2'd0, 1'b0, 1'b0);
        check("after_reset_first",  32'(r_first), 32'd0);
        check("after_reset_lat",    32'(r_lat),   32'd2);
        check("after_reset_errors", 32'(r_err),   32'd0);

        // start held high: back-to-back frames; second frame sees mode ~0 = ROT180
        run_frame(2'd0, 1'b0, 1'b1);
        check("hold_errors", 32'(r_err),   32'd0);
        check("hold_done1",  32'(r_done1), 32'd1);
        check("hold_gap",    32'({r_done2, r_busy2}), 32'd0);
        @(posedge clk);
        @(negedge clk);
        check("hold_restart_busy", 32'({busy, valid}), 32'b10);
        @(posedge clk);
        @(negedge clk);
        check("hold_restart_valid_early", 32'(valid), 32'd0);
        @(posedge clk);
        @(negedge clk);
        check("hold_restart_valid", 32'(valid), 32'd1);
        check("hold_restart_first", 32'(pixel), 32'd15);
        start = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pixel_stream_gen.md
PIXEL_STREAM_GEN -- requirements
Module: pixel_stream_gen

Interface
REQ-001 Parameter IMG_W, default 28, image columns (>=2).
REQ-002 Parameter IMG_H, default 28, image rows (>=2).
REQ-003 Parameter PIX_W, default 8, bits per pixel.
REQ-004 Parameter LANES, default 1, pixels per output beat; IMG_W % LANES == 0, else elaboration error.
REQ-005 Port clk_i  input  1  single clock, rising edge.
REQ-006 Port rst_ni  input  1  reset, asynchronous, active-low.
REQ-007 Port start_i  input  1  frame request; sampled only in IDLE.
REQ-008 Port mode_i  input  2  address mode: 0 IDENT, 1 HFLIP, 2 VFLIP, 3 ROT180; latched on accepted start.
REQ-009 Port ready_i  input  1  downstream ready.
REQ-010 Port pixel_o  output  LANES*PIX_W  pixel beat, lane k in bits [k*PIX_W +: PIX_W].
REQ-011 Port valid_o  output  1  pixel_o/last_o valid.
REQ-012 Port last_o  output  1  final beat of frame, qualified by valid_o.
REQ-013 Port busy_o  output  1  high from accepted start until done_o cycle inclusive.
REQ-014 Port done_o  output  1  one-cycle pulse, frame complete.

Function
REQ-015 FSM states IDLE, RUN, DRAIN; IDLE->RUN on start_i in IDLE; RUN->DRAIN when last address issued; DRAIN->IDLE on handshake of last beat.
REQ-016 Output order raster: output row r (0..IMG_H-1), output column c (0..IMG_W-1), LANES consecutive columns per beat, lane 0 = lowest c.
REQ-017 Source address per lane: IDENT r*IMG_W+c; HFLIP r*IMG_W+(IMG_W-1-c); VFLIP (IMG_H-1-r)*IMG_W+c; ROT180 IMG_W*IMG_H-1-(r*IMG_W+c).
REQ-018 Address width $clog2(IMG_W*IMG_H); row/column counters wrap column to 0 and increment row at IMG_W-LANES; no multiplier on the beat path (running row-base register).
REQ-019 Pixel source: synchronous ROM, one-cycle read latency, LANES read ports.
REQ-020 Handshake: beat transfers when valid_o && ready_i; while valid_o && !ready_i, pixel_o, last_o, valid_o held stable.
REQ-021 valid_o never deasserts without a handshake once asserted.
REQ-022 First valid_o two cycles after accepted start; with ready_i held high, one beat per cycle, no bubbles, frame = IMG_W*IMG_H/LANES beats.
REQ-023 Latency-1 ROM under backpressure covered by a 2-entry skid buffer; address counter advances only when the skid buffer has space.
REQ-024 last_o high only on final beat; done_o pulses the cycle after its handshake; busy_o drops with done_o.
REQ-025 start_i while busy_o ignored, no effect on current frame; start_i in done_o cycle ignored; start_i the cycle after done_o accepted.
REQ-026 mode_i changes during a frame have no effect.
REQ-027 ready_i before valid_o has no effect.

Reset
REQ-028 On rst_ni low, immediately: state IDLE, counters 0, skid buffer empty, pixel_o 0, valid_o 0, last_o 0, busy_o 0, done_o 0.
REQ-029 Reset mid-frame abandons the frame; no done_o; next start begins at beat 0.

Structure
REQ-030 Package pixel_stream_pkg holds mode_e enum (IDENT, HFLIP, VFLIP, ROT180) and state_e enum.
REQ-031 Sub-module pixel_rom (parametrised depth, PIX_W, LANES ports, sync read, init file parameter) is the only child.
REQ-032 Skid buffer and address generator inline in pixel_stream_gen.

Verification (ROM init pixel[a] = a mod 256, IMG 28x28, PIX_W 8)
REQ-033 LANES=1, IDENT, start pulse, ready_i=1 -> valid_o 2 cycles later, 784 beats values 0,1,..,255,0,..,15, last_o on beat 784 only, done_o next cycle.
REQ-034 LANES=1, HFLIP -> beats 27,26,..,0,55,..; ROT180 -> first beat 15 (783 mod 256), last beat 0.
REQ-035 IDENT, ready_i toggled pseudo-random 50% -> identical 784-value sequence, pixel_o stable during every stall, no drop/duplicate.
REQ-036 LANES=4, VFLIP, ready_i=1 -> 196 beats, first beat pixel_o = {7,6,5,4}+{...} i.e. lanes 0..3 = 244,245,246,247 (756..759 mod 256).
REQ-037 start_i re-pulsed at beat 100 -> ignored; rst_ni low at beat 300 -> all outputs 0 same cycle, no done_o; new start -> beat 0 value 0.
REQ-038 start_i held high continuously -> back-to-back frames, one idle cycle between done_o and next accepted start.
